// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
//   Shared definitions for the word-granular cache<->memory interface:
//   word width, default responder geometry, request classification and the
//   byte-address to word-index helper.
// ---------------------------------------------------------------------------
package mem_if_pkg;

   localparam int WORD_W         = 32;
   localparam int DEF_DEPTH_W    = 1024;
   localparam int DEF_LATENCY    = 3;
   localparam int DEF_MAX_OUTST  = 4;
   localparam int DEF_WR_RECOVER = 1;

   typedef logic [WORD_W-1:0] word_t;

   // What the responder does with the request presented this cycle.
   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_READ,
      REQ_WRITE
   } req_kind_t;

   // Byte address -> word index. Bits [1:0] select a byte within the word
   // and are dropped. Bits above the array size are masked off, so the
   // address space wraps onto the array. depth must be a power of 2.
   function automatic word_t word_index(input word_t addr, input int unsigned depth);
      return (addr >> 2) & (WORD_W'(depth) - word_t'(1));
   endfunction

endpackage

// File: rtl/rsp_delay_line.sv
// ---------------------------------------------------------------------------
// rsp_delay_line
//   Fixed-latency shift register carrying {valid, data}. An entry pushed at
//   an edge appears on valid/data in the cycle after LATENCY-1 further
//   edges. It shifts every cycle and cannot be stalled. Reset flushes every
//   stage, so no in-flight response survives a reset.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high flush
//   push       in   1   enter a response this edge
//   push_data  in   W   data travelling with the response
//   valid      out  1   response present at the output stage
//   data       out  W   output stage data (meaningful while valid)
// ---------------------------------------------------------------------------
module rsp_delay_line
   import mem_if_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY,
   parameter int W       = WORD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_q [LATENCY];
   logic [W-1:0] data_q  [LATENCY];

   // NOTE: sequential state uses non-blocking assignments only, so every
   // stage samples the pre-edge value of the stage before it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
         end
      end else begin
         valid_q[0] <= push;
         data_q[0]  <= push_data;
         for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign valid = valid_q[LATENCY-1];
   assign data  = data_q[LATENCY-1];

endmodule

// File: rtl/word_mem_responder.sv
// ---------------------------------------------------------------------------
// word_mem_responder
//   Memory-side responder for one cache. It holds a word-addressed backing
//   array, accepts one read or write per cycle while ready, and returns read
//   data in acceptance order exactly LATENCY cycles later. Ready throttles
//   the cache when MAX_OUTST reads are in flight and for WR_RECOVER cycles
//   after each accepted write.
//
// Ports
//   i_clk        in   1   clock, rising edge
//   i_rst        in   1   asynchronous, active-high reset
//   i_mem_addr   in   32  byte address (bits [1:0] ignored, upper bits wrap)
//   i_mem_ren    in   1   read request
//   i_mem_wen    in   1   write request (wins over a simultaneous read)
//   i_mem_wdata  in   32  full-word write data
//   o_mem_ready  out  1   a request can be accepted this cycle
//   o_mem_rdata  out  32  read data, meaningful while o_mem_valid
//   o_mem_valid  out  1   one-cycle pulse per accepted read
// ---------------------------------------------------------------------------
module word_mem_responder
   import mem_if_pkg::*;
#(
   parameter int DEPTH_W    = DEF_DEPTH_W,
   parameter int LATENCY    = DEF_LATENCY,
   parameter int MAX_OUTST  = DEF_MAX_OUTST,
   parameter int WR_RECOVER = DEF_WR_RECOVER
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [WORD_W-1:0] i_mem_addr,
   input  logic              i_mem_ren,
   input  logic              i_mem_wen,
   input  logic [WORD_W-1:0] i_mem_wdata,
   output logic              o_mem_ready,
   output logic [WORD_W-1:0] o_mem_rdata,
   output logic              o_mem_valid
);

   localparam int IDX_W = $clog2(DEPTH_W);
   localparam int OUT_W = $clog2(MAX_OUTST + 1);
   localparam int REC_W = (WR_RECOVER > 0) ? $clog2(WR_RECOVER + 1) : 1;

   word_t            mem [DEPTH_W];
   word_t            idx_full;
   logic [IDX_W-1:0] idx;
   logic             unused_idx_bits;

   logic [OUT_W-1:0] outst_cnt;
   logic [REC_W-1:0] wr_rec_cnt;
   req_kind_t        req;
   logic             rd_push;

   // ---- address decode ----------------------------------------------------
   assign idx_full        = word_index(i_mem_addr, DEPTH_W);
   assign idx             = idx_full[IDX_W-1:0];
   // The helper already masks these bits to zero.
   assign unused_idx_bits = &{1'b0, idx_full[WORD_W-1:IDX_W]};

   // ---- ready: Moore on internal state, forced low during reset -----------
   assign o_mem_ready = ~i_rst
                      & (outst_cnt < OUT_W'(MAX_OUTST))
                      & (wr_rec_cnt == '0);

   // ---- accept decode: write has priority over an illegal read+write ------
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      req = REQ_NONE;
      if (o_mem_ready) begin
         if (i_mem_wen) begin
            req = REQ_WRITE;
         end else if (i_mem_ren) begin
            req = REQ_READ;
         end
      end
   end

   assign rd_push = (req == REQ_READ);

   // ---- backing array -----------------------------------------------------
   // NOTE: the array has no reset; contents survive i_rst and the storage
   // can map onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (req == REQ_WRITE) begin
         mem[idx] <= i_mem_wdata;
      end
   end

   // The read word is taken from the array as it stands before this edge,
   // so it sees writes accepted at earlier edges and is immune to later
   // writes once captured.
   rsp_delay_line #(
      .LATENCY (LATENCY),
      .W       (WORD_W)
   ) u_rsp_delay_line (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (rd_push),
      .push_data (mem[idx]),
      .valid     (o_mem_valid),
      .data      (o_mem_rdata)
   );

   // ---- outstanding read count --------------------------------------------
   // A read leaves the count at the edge that ends its valid cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         outst_cnt <= '0;
      end else begin
         case ({rd_push, o_mem_valid})
            2'b10:   outst_cnt <= outst_cnt + OUT_W'(1);
            2'b01:   outst_cnt <= outst_cnt - OUT_W'(1);
            default: outst_cnt <= outst_cnt;
         endcase
      end
   end

   // ---- write recovery ------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_rec_cnt <= '0;
      end else if (req == REQ_WRITE) begin
         wr_rec_cnt <= REC_W'(WR_RECOVER);
      end else if (wr_rec_cnt != '0) begin
         wr_rec_cnt <= wr_rec_cnt - REC_W'(1);
      end
   end

endmodule

// File: tb/tb_word_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_word_mem_responder
//   Directed bench for word_mem_responder. The main instance uses the
//   default geometry (DEPTH_W=1024, LATENCY=3, MAX_OUTST=4, WR_RECOVER=1).
//   A second instance with MAX_OUTST=2 shows throttling on the outstanding
//   read limit. Outputs are sampled 1 ns after the rising edge; inputs
//   change at the same point.
// ---------------------------------------------------------------------------
module tb_word_mem_responder;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] addr, wdata;
   logic        ren, wen;
   logic        ready, valid;
   logic [31:0] rdata;

   logic [31:0] addr2, wdata2;
   logic        ren2, wen2;
   logic        ready2, valid2;
   logic [31:0] rdata2;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   word_mem_responder dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_mem_addr  (addr),
      .i_mem_ren   (ren),
      .i_mem_wen   (wen),
      .i_mem_wdata (wdata),
      .o_mem_ready (ready),
      .o_mem_rdata (rdata),
      .o_mem_valid (valid)
   );

   word_mem_responder #(
      .MAX_OUTST (2)
   ) dut2 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_mem_addr  (addr2),
      .i_mem_ren   (ren2),
      .i_mem_wen   (wen2),
      .i_mem_wdata (wdata2),
      .o_mem_ready (ready2),
      .o_mem_rdata (rdata2),
      .o_mem_valid (valid2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write, then sit out the one-cycle write recovery.
   task automatic write_word(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wen   = 1'b1;
      step();
      wen   = 1'b0;
      step();
   endtask

   task automatic write_word2(input logic [31:0] a, input logic [31:0] d);
      addr2  = a;
      wdata2 = d;
      wen2   = 1'b1;
      step();
      wen2   = 1'b0;
      step();
   endtask

   // Read accepted at edge A; the response must be visible after A+2 only.
   task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      ren  = 1'b1;
      step();
      ren  = 1'b0;
      step();
      step();
      check({tag, " valid"}, 32'(valid), 32'd1);
      check({tag, " rdata"}, rdata, exp);
      step();
      check({tag, " valid end"}, 32'(valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int acc;
      int nv;
      logic take;
      logic exp_ready [9];
      logic exp_valid [9];

      rst = 1'b1;
      ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
      ren2 = 1'b0; wen2 = 1'b0; addr2 = '0; wdata2 = '0;

      // ---- reset state ----------------------------------------------------
      #3;
      check("rst ready", 32'(ready), 32'd0);
      check("rst valid", 32'(valid), 32'd0);
      check("rst rdata", rdata, 32'd0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("ready after release", 32'(ready), 32'd1);

      // ---- 1: write then read same word, write recovery -------------------
      addr  = 32'h40;
      wdata = 32'hDEAD_BEEF;
      wen   = 1'b1;
      step();
      wen   = 1'b0;
      check("t1 ready low after write", 32'(ready), 32'd0);
      ren   = 1'b1;
      step();                                  // read ignored while not ready
      check("t1 ready back", 32'(ready), 32'd1);
      check("t1 no valid yet", 32'(valid), 32'd0);
      step();                                  // read accepted
      ren = 1'b0;
      check("t1 valid A", 32'(valid), 32'd0);
      step();
      check("t1 valid A+1", 32'(valid), 32'd0);
      step();
      check("t1 valid A+2", 32'(valid), 32'd1);
      check("t1 rdata", rdata, 32'hDEAD_BEEF);
      step();
      check("t1 valid A+3", 32'(valid), 32'd0);

      // ---- 2: cache-line burst ---------------------------------------------
      for (int i = 0; i < 4; i++) write_word(32'h100 + 32'(4 * i), 32'(i + 1));
      for (int c = 0; c < 7; c++) begin
         ren  = (c < 4);
         addr = 32'h100 + 32'(4 * c);
         step();
         check($sformatf("t2 ready c%0d", c), 32'(ready), 32'd1);
         check($sformatf("t2 valid c%0d", c), 32'(valid), 32'((c >= 2) && (c <= 5)));
         if (c >= 2 && c <= 5) check($sformatf("t2 rdata c%0d", c), rdata, 32'(c - 1));
      end
      ren = 1'b0;

      // ---- 3: outstanding limit on the MAX_OUTST=2 instance ------------------
      for (int i = 0; i < 4; i++) write_word2(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
      check("t3 ready start", 32'(ready2), 32'd1);
      exp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      acc = 0;
      nv  = 0;
      for (int k = 0; k < 9; k++) begin
         ren2  = (k < 6);
         addr2 = 32'h200 + 32'(4 * acc);
         take  = ren2 & ready2;
         step();
         if (take) acc++;
         check($sformatf("t3 ready e%0d", k), 32'(ready2), 32'(exp_ready[k]));
         check($sformatf("t3 valid e%0d", k), 32'(valid2), 32'(exp_valid[k]));
         if (valid2) begin
            check($sformatf("t3 rdata e%0d", k), rdata2, 32'hA0 + 32'(nv));
            nv++;
         end
      end
      ren2 = 1'b0;
      check("t3 accepts", 32'(acc), 32'd4);
      check("t3 valids", 32'(nv), 32'd4);

      // ---- 4: address wrap and ignored byte offset --------------------------
      write_word(32'h1000, 32'h55);
      read_check("t4 wrap", 32'h0000, 32'h55);
      read_check("t4 offset", 32'h0003, 32'h55);

      // ---- 5: async reset with reads in flight -----------------------------
      for (int i = 0; i < 3; i++) begin
         ren  = 1'b1;
         addr = 32'h100 + 32'(4 * i);
         step();
      end
      ren = 1'b0;
      check("t5 valid before rst", 32'(valid), 32'd1);
      check("t5 rdata before rst", rdata, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check("t5 rst valid", 32'(valid), 32'd0);
      check("t5 rst ready", 32'(ready), 32'd0);
      check("t5 rst rdata", rdata, 32'd0);
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      check("t5 ready after release", 32'(ready), 32'd1);
      for (int c = 0; c < 4; c++) begin
         step();
         check($sformatf("t5 no stale valid c%0d", c), 32'(valid), 32'd0);
      end
      read_check("t5 keep 0x40", 32'h40, 32'hDEAD_BEEF);
      read_check("t5 keep 0x10C", 32'h10C, 32'd4);

      // ---- 6: simultaneous read and write ----------------------------------
      addr  = 32'h20;
      wdata = 32'h7;
      ren   = 1'b1;
      wen   = 1'b1;
      step();
      ren = 1'b0;
      wen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("t6 no valid c%0d", c), 32'(valid), 32'd0);
         step();
      end
      read_check("t6 readback", 32'h20, 32'h7);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
